// File: rtl/dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// dcache_write_buffer
//
// Line-granular posted write buffer between the data cache memory port and
// slow memory. Dirty-line evictions are absorbed in one cycle into a small
// circular FIFO and drained to memory in the background. Line-fill reads are
// answered from the buffer when the line is present (youngest copy wins).
// Otherwise they are forwarded to memory ahead of any drains still queued.
// The cache-side handshake mirrors the memory handshake, so the cache can be
// attached without change.
//
// Ports
//   clk, proc_reset       clock, asynchronous active-high reset
//   c_read / c_write      cache line read / eviction request, held until c_ready
//   c_addr, c_wdata       request line address and eviction data
//   c_rdata, c_ready      read data and one-cycle completion pulse to the cache
//   mem_read / mem_write  memory requests, held until mem_ready
//   mem_addr, mem_wdata   memory line address and write data
//   mem_rdata, mem_ready  memory read data and completion pulse
//   wb_empty              nothing buffered and no drain in flight
// -----------------------------------------------------------------------------
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [LINE_W-1:0] c_wdata,
    output logic [LINE_W-1:0] c_rdata,
    output logic              c_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              wb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        RD,
        RESP
    } state_t;

    state_t state;

    // Entry storage. Only the valid bits are control state; address and data
    // are meaningful only under a set valid bit.
    logic [DEPTH-1:0]  ent_valid;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [LINE_W-1:0] ent_data [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              head_busy;
    logic              sample;
    logic              req_write;
    logic              req_read;

    logic              rd_hit;
    logic [PTR_W-1:0]  rd_idx;
    logic              wr_hit;
    logic [PTR_W-1:0]  wr_idx;

    logic              rd_miss;
    logic              push;
    logic              coal;
    logic              pop;
    logic [LINE_W-1:0] launch_data;

    assign full      = (count == CNT_W'(DEPTH));
    assign head_busy = (state == DRAIN);

    // While c_ready is high the cache is still releasing its previous request;
    // looking at the request lines then would accept it a second time. Reads
    // and writes are only taken while the memory port is idle or draining,
    // since during a read miss the cache is stalled on that read.
    assign sample    = !c_ready && ((state == IDLE) || (state == DRAIN));
    assign req_write = sample && c_write;
    assign req_read  = sample && c_read && !c_write;

    // Associative search, oldest to youngest, so the last match seen is the
    // youngest copy. Reads may hit the in-flight head; writes may not merge
    // into it because its data is already on the memory bus.
    always_comb begin
        rd_hit = 1'b0;
        rd_idx = '0;
        wr_hit = 1'b0;
        wr_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[head + PTR_W'(i)] && (ent_addr[head + PTR_W'(i)] == c_addr)) begin
                rd_hit = 1'b1;
                rd_idx = head + PTR_W'(i);
                if (!(head_busy && (i == 0))) begin
                    wr_hit = 1'b1;
                    wr_idx = head + PTR_W'(i);
                end
            end
        end
    end

    assign rd_miss = req_read && !rd_hit;
    assign coal    = req_write && wr_hit;
    // A full buffer only frees space on the edge after the pop, so a stalled
    // write is never pushed on the same edge as the pop that makes room.
    assign push    = req_write && !wr_hit && !full;
    assign pop     = (state == DRAIN) && mem_ready;

    // A write may merge into the head on the very edge its drain launches
    // (the head is not yet in flight); forward the new data so it is not lost.
    assign launch_data = (coal && (wr_idx == head)) ? c_wdata : ent_data[head];

    assign wb_empty = (count == '0) && (state != DRAIN);

    // Control state, FSM and registered outputs.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state     <= IDLE;
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            c_ready   <= 1'b0;
            c_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            c_ready <= 1'b0;

            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (push || coal) begin
                c_ready <= 1'b1;
            end

            if (req_read && rd_hit) begin
                c_rdata <= ent_data[rd_idx];
                c_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // A pending fill stalls the processor, so it goes first.
                    if (rd_miss) begin
                        state    <= RD;
                        mem_read <= 1'b1;
                        mem_addr <= c_addr;
                    end else if (count != '0) begin
                        state     <= DRAIN;
                        mem_write <= 1'b1;
                        mem_addr  <= ent_addr[head];
                        mem_wdata <= launch_data;
                    end
                end
                DRAIN: begin
                    // Never aborted; a read miss waits until this completes.
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        c_rdata  <= mem_rdata;
                        c_ready  <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Entry payload: written on push, or overwritten in place on coalesce.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= c_addr;
            ent_data[tail] <= c_wdata;
        end else if (coal) begin
            ent_data[wr_idx] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
module tb_dcache_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

    localparam int PH_IDLE  = 0;
    localparam int PH_DRAIN = 1;
    localparam int PH_READ  = 2;
    localparam int PH_RESP  = 3;

    logic              clk        = 1'b0;
    logic              proc_reset = 1'b1;
    logic              c_read     = 1'b0;
    logic              c_write    = 1'b0;
    logic [ADDR_W-1:0] c_addr     = '0;
    logic [LINE_W-1:0] c_wdata    = '0;
    logic [LINE_W-1:0] c_rdata;
    logic              c_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata  = '0;
    logic              mem_ready  = 1'b0;
    logic              wb_empty;

    dcache_write_buffer #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .c_read    (c_read),
        .c_write   (c_write),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_rdata   (c_rdata),
        .c_ready   (c_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .wb_empty  (wb_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- slow memory model ----------------
    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
    } mev_t;

    logic [LINE_W-1:0] mem_arr [logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] latest  [logic [ADDR_W-1:0]];
    mev_t mlog[$];
    int mem_lat        = 1;
    int mcnt           = 0;
    int last_ready_cyc = 0;

    function automatic logic [LINE_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return {4{4'hA, a}};
    endfunction

    function automatic logic [LINE_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_val(a);
    endfunction

    function automatic logic [LINE_W-1:0] exp_latest(input logic [ADDR_W-1:0] a);
        if (latest.exists(a)) return latest[a];
        return init_val(a);
    endfunction

    function automatic int n_reads();
        int n = 0;
        foreach (mlog[i]) if (!mlog[i].wr) n++;
        return n;
    endfunction

    initial begin : mem_proc
        mev_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (proc_reset) begin
                mem_ready = 1'b0;
                mcnt      = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_read || mem_write) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    mcnt           = 0;
                    mem_ready      = 1'b1;
                    last_ready_cyc = cyc;
                    ev.wr = mem_write;
                    ev.a  = mem_addr;
                    if (mem_write) begin
                        mem_arr[mem_addr] = mem_wdata;
                        ev.d = mem_wdata;
                    end else begin
                        mem_rdata = mem_val(mem_addr);
                        ev.d = mem_rdata;
                    end
                    mlog.push_back(ev);
                end
            end
        end
    end

    // ---------------- behavioural buffer model ----------------
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
    } ent_t;

    ent_t q[$];
    int                ph        = PH_IDLE;
    bit                exp_ready = 1'b0;
    logic [LINE_W-1:0] exp_rdata = '0;
    logic [ADDR_W-1:0] rd_addr   = '0;

    initial begin : model_proc
        int   j;
        int   sz0;
        bit   smp;
        bit   rmiss;
        bit   nready;
        ent_t e;
        forever begin
            @(negedge clk);
            if (proc_reset) begin
                q.delete();
                ph        = PH_IDLE;
                exp_ready = 1'b0;
            end else begin
                chk("c_ready", LINE_W'(c_ready), LINE_W'(exp_ready));
                if (exp_ready) chk("c_rdata", c_rdata, exp_rdata);
                chk("mem_write", LINE_W'(mem_write), LINE_W'(ph == PH_DRAIN));
                chk("mem_read", LINE_W'(mem_read), LINE_W'(ph == PH_READ));
                if (ph == PH_DRAIN) begin
                    chk("drain_addr", LINE_W'(mem_addr), LINE_W'(q[0].a));
                    chk("drain_data", mem_wdata, q[0].d);
                end
                if (ph == PH_READ) chk("miss_addr", LINE_W'(mem_addr), LINE_W'(rd_addr));
                chk("wb_empty", LINE_W'(wb_empty), LINE_W'(q.size() == 0));

                // Predict the effect of the coming clock edge.
                sz0    = q.size();
                smp    = !exp_ready && (ph == PH_IDLE || ph == PH_DRAIN);
                rmiss  = 1'b0;
                nready = 1'b0;
                if (smp && c_write) begin
                    j = -1;
                    foreach (q[i]) if (q[i].a == c_addr && !(i == 0 && ph == PH_DRAIN)) j = i;
                    if (j >= 0) begin
                        e = q[j];
                        e.d = c_wdata;
                        q[j] = e;
                        nready = 1'b1;
                    end else if (sz0 < DEPTH) begin
                        e.a = c_addr;
                        e.d = c_wdata;
                        q.push_back(e);
                        nready = 1'b1;
                    end
                end else if (smp && c_read) begin
                    j = -1;
                    foreach (q[i]) if (q[i].a == c_addr) j = i;
                    if (j >= 0) begin
                        exp_rdata = q[j].d;
                        nready    = 1'b1;
                    end else begin
                        rmiss = 1'b1;
                    end
                end
                case (ph)
                    PH_IDLE: begin
                        if (rmiss) begin
                            ph      = PH_READ;
                            rd_addr = c_addr;
                        end else if (sz0 > 0) begin
                            ph = PH_DRAIN;
                        end
                    end
                    PH_DRAIN: begin
                        if (mem_ready) begin
                            void'(q.pop_front());
                            ph = PH_IDLE;
                        end
                    end
                    PH_READ: begin
                        if (mem_ready) begin
                            exp_rdata = mem_rdata;
                            nready    = 1'b1;
                            ph        = PH_RESP;
                        end
                    end
                    default: ph = PH_IDLE;
                endcase
                exp_ready = nready;
            end
        end
    end

    // ---------------- cache-side driver ----------------
    int op_cyc = 0;

    task automatic cache_op(input bit wr, input bit both, input logic [ADDR_W-1:0] a,
                            input logic [LINE_W-1:0] d, output logic [LINE_W-1:0] rd,
                            output int polls);
        polls   = 0;
        c_addr  = a;
        c_wdata = wr ? d : '0;
        c_write = wr;
        c_read  = !wr || both;
        do begin
            @(posedge clk);
            #1;
            polls++;
        end while (!c_ready && polls < 300);
        chk("handshake", LINE_W'(c_ready), LINE_W'(1));
        op_cyc  = cyc;
        rd      = c_rdata;
        c_read  = 1'b0;
        c_write = 1'b0;
        if (wr) latest[a] = d;
        else chk("read_coherent", rd, exp_latest(a));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!(wb_empty && !mem_write && !mem_read && !mem_ready) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", LINE_W'(wb_empty), LINE_W'(1));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [LINE_W-1:0] rd;
        int polls;
        int base;
        int nr0;
        logic [LINE_W-1:0] dv [5];

        proc_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c_ready", LINE_W'(c_ready), '0);
        chk("rst_c_rdata", c_rdata, '0);
        chk("rst_mem_read", LINE_W'(mem_read), '0);
        chk("rst_mem_write", LINE_W'(mem_write), '0);
        chk("rst_mem_addr", LINE_W'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_wb_empty", LINE_W'(wb_empty), LINE_W'(1));
        proc_reset = 1'b0;
        @(posedge clk);
        #1;

        // Single write, then background drain.
        mem_lat = 3;
        base = mlog.size();
        cache_op(1'b1, 1'b0, 28'h0000010, 128'hA, rd, polls);
        chk("wr_ready_latency", LINE_W'(polls), LINE_W'(1));
        wait_empty();
        chk("wr_one_mem_op", LINE_W'(mlog.size() - base), LINE_W'(1));
        chk("wr_mem_is_write", LINE_W'(mlog[base].wr), LINE_W'(1));
        chk("wr_mem_addr", LINE_W'(mlog[base].a), LINE_W'(28'h0000010));
        chk("wr_mem_data", mlog[base].d, 128'hA);

        // Read hit while the line is still buffered.
        mem_lat = 12;
        nr0 = n_reads();
        cache_op(1'b1, 1'b0, 28'h0000010, 128'hA2, rd, polls);
        cache_op(1'b0, 1'b0, 28'h0000010, '0, rd, polls);
        chk("hit_data", rd, 128'hA2);
        chk("hit_latency", LINE_W'(polls), LINE_W'(1));
        wait_empty();
        chk("hit_no_mem_read", LINE_W'(n_reads()), LINE_W'(nr0));

        // Coalesce into a queued (not in-flight) entry.
        mem_lat = 20;
        base = mlog.size();
        cache_op(1'b1, 1'b0, 28'h0000040, 128'h40, rd, polls);
        cache_op(1'b1, 1'b0, 28'h0000010, 128'hA, rd, polls);
        cache_op(1'b1, 1'b0, 28'h0000020, 128'hB, rd, polls);
        cache_op(1'b1, 1'b0, 28'h0000010, 128'hC, rd, polls);
        chk("coal_not_empty", LINE_W'(wb_empty), '0);
        wait_empty();
        chk("coal_three_writes", LINE_W'(mlog.size() - base), LINE_W'(3));
        chk("coal_w0_addr", LINE_W'(mlog[base].a), LINE_W'(28'h40));
        chk("coal_w1_addr", LINE_W'(mlog[base + 1].a), LINE_W'(28'h10));
        chk("coal_w1_data", mlog[base + 1].d, 128'hC);
        chk("coal_w2_addr", LINE_W'(mlog[base + 2].a), LINE_W'(28'h20));
        chk("coal_w2_data", mlog[base + 2].d, 128'hB);

        // Fill all entries with slow memory, then one more write.
        mem_lat = 8;
        base = mlog.size();
        for (int i = 0; i < 5; i++) begin
            dv[i] = {4{32'hD0D0_0000 + 32'(i)}};
            cache_op(1'b1, 1'b0, 28'h0000100 + 28'(i), dv[i], rd, polls);
        end
        chk("full_stalled", LINE_W'(polls > 1), LINE_W'(1));
        chk("full_accept_after_pop", LINE_W'(op_cyc - last_ready_cyc), LINE_W'(2));
        wait_empty();
        chk("full_five_writes", LINE_W'(mlog.size() - base), LINE_W'(5));
        for (int i = 0; i < 5; i++) begin
            chk("full_order_addr", LINE_W'(mlog[base + i].a), LINE_W'(28'h0000100 + 28'(i)));
            chk("full_order_data", mlog[base + i].d, dv[i]);
        end

        // Read miss during a drain: waits, then overtakes the remaining drain.
        mem_lat = 8;
        base = mlog.size();
        cache_op(1'b1, 1'b0, 28'h0000010, 128'hE, rd, polls);
        cache_op(1'b1, 1'b0, 28'h0000020, 128'hF, rd, polls);
        cache_op(1'b0, 1'b0, 28'h0000099, '0, rd, polls);
        chk("miss_data", rd, init_val(28'h0000099));
        wait_empty();
        chk("miss_ops", LINE_W'(mlog.size() - base), LINE_W'(3));
        chk("miss_first_w10", LINE_W'({mlog[base].wr, mlog[base].a}), LINE_W'({1'b1, 28'h10}));
        chk("miss_then_r99", LINE_W'({mlog[base + 1].wr, mlog[base + 1].a}), LINE_W'({1'b0, 28'h99}));
        chk("miss_last_w20", LINE_W'({mlog[base + 2].wr, mlog[base + 2].a}), LINE_W'({1'b1, 28'h20}));

        // Reset in the middle of a drain with three entries buffered.
        mem_lat = 30;
        cache_op(1'b1, 1'b0, 28'h0000010, 128'h111, rd, polls);
        cache_op(1'b1, 1'b0, 28'h0000020, 128'h222, rd, polls);
        cache_op(1'b1, 1'b0, 28'h0000030, 128'h333, rd, polls);
        chk("pre_rst_busy", LINE_W'({mem_write, wb_empty}), LINE_W'(2'b10));
        #2;
        proc_reset = 1'b1;
        #1;
        chk("midrst_mem_write", LINE_W'(mem_write), '0);
        chk("midrst_wb_empty", LINE_W'(wb_empty), LINE_W'(1));
        chk("midrst_c_ready", LINE_W'(c_ready), '0);
        repeat (2) @(posedge clk);
        #1;
        proc_reset = 1'b0;
        latest.delete();
        foreach (mem_arr[k]) latest[k] = mem_arr[k];
        nr0 = n_reads();
        mem_lat = 2;
        cache_op(1'b0, 1'b0, 28'h0000020, '0, rd, polls);
        chk("postrst_read_mem", LINE_W'(n_reads()), LINE_W'(nr0 + 1));
        chk("postrst_data", rd, 128'hF);

        // Randomized traffic over a small address set.
        for (int n = 0; n < 400; n++) begin
            bit wr;
            bit both;
            logic [ADDR_W-1:0] a;
            if ($urandom_range(0, 15) == 0) mem_lat = $urandom_range(1, 6);
            wr   = ($urandom_range(0, 9) < 6);
            both = wr && ($urandom_range(0, 7) == 0);
            a    = wr ? 28'($urandom_range(0, 7)) : 28'($urandom_range(0, 11));
            cache_op(wr, both, a, {$urandom(), $urandom(), $urandom(), $urandom()}, rd, polls);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_empty();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- Line-granular posted write buffer between the data cache's memory port and slow_memD.
- Dirty-line evictions from the cache complete in one cycle and are drained to slow memory in the background.
- Line-fill reads are served from the buffer on an address match; otherwise they are forwarded to memory ahead of pending drains.
- The cache-side interface mirrors the slow-memory handshake, so the cache connects without modification.

Parameters:
DEPTH, 4, number of buffered line entries (power of two, >=2)
ADDR_W, 28, line address width (byte address bits 31:4)
LINE_W, 128, line data width

Ports:
clk  input  1  system clock
proc_reset  input  1  asynchronous, active-high reset
c_read  input  1  cache line-read request, held until c_ready
c_write  input  1  cache line-write (eviction) request, held until c_ready
c_addr  input  ADDR_W  cache request line address
c_wdata  input  LINE_W  eviction data
c_rdata  output  LINE_W  read data, valid while c_ready=1
c_ready  output  1  one-cycle completion pulse to cache
mem_read  output  1  memory read request, held until mem_ready
mem_write  output  1  memory write request, held until mem_ready
mem_addr  output  ADDR_W  memory line address
mem_wdata  output  LINE_W  memory write data
mem_rdata  input  LINE_W  memory read data
mem_ready  input  1  memory completion pulse
wb_empty  output  1  no valid entries and no drain in flight

Behaviour:
- Storage: DEPTH-entry circular FIFO (valid, addr, data).
  - head/tail pointers wrap modulo DEPTH.
  - count is 0..DEPTH; full = (count==DEPTH).
- Reset (async, any state, including mid-transaction): all entries invalid, pointers and count 0, FSM=IDLE.
  - c_ready=0, c_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, wb_empty=1.
  - Any in-flight memory transaction is abandoned.
- Cache side:
  - A request is sampled only in cycles where c_ready=0; this prevents double acceptance while the cache releases the request.
  - c_read and c_write are never both high; if they are, c_write wins.
- Write accept:
  - If a valid, not-in-flight entry has the same addr, overwrite its data in place (coalesce); count unchanged.
  - Else, if not full, push at tail.
  - c_ready is asserted the next cycle (registered, 1-cycle latency).
  - If full and no coalesce target exists, the request is held. Acceptance happens the first cycle after count drops below DEPTH; no same-edge push/pop bypass.
- Read:
  - Search all valid entries, including the in-flight head.
  - Hit: the youngest matching entry wins. c_rdata = entry data with c_ready on the next cycle; no memory access.
  - Miss: the request is forwarded to memory via FSM state RD.
- FSM states IDLE, DRAIN, RD, RESP:
  - IDLE -> RD on a pending read miss. This has priority over draining.
  - IDLE -> DRAIN when count>0 and no read miss is pending.
  - DRAIN: mem_write=1, mem_addr/mem_wdata = head entry. On mem_ready: pop head (count-1, head+1), then go to IDLE.
    - A drain in flight is never aborted; a read miss arriving during DRAIN waits.
  - RD: mem_read=1, mem_addr=c_addr. On mem_ready: capture mem_rdata into c_rdata, go to RESP.
  - RESP: c_ready=1 for exactly one cycle, then IDLE.
- Memory-side outputs are registered. mem_read/mem_write are never high together and drop the cycle after mem_ready.
- A write that arrives during DRAIN may push or coalesce into non-head entries concurrently. Coalescing into the in-flight head is forbidden; a matching write becomes a new entry.
- wb_empty = (count==0) and FSM not in DRAIN.
- Ordering guarantee: entries reach memory in FIFO order; a later coalesced write never reorders relative to other addresses.

Test Plan:
- Reset mid-DRAIN (count=3) -> next cycle mem_write=0, wb_empty=1, c_ready=0; subsequent read of any addr goes to memory.
- Write addr 0x0000010, data A -> c_ready exactly one cycle later; mem_write with addr 0x0000010 / data A issued afterwards; after mem_ready, wb_empty=1.
- Write 0x10=A then read 0x10 before drain completes -> c_rdata=A, c_ready one cycle after read sampled, mem_read never asserted.
- Write 0x10=A, write 0x20=B, write 0x10=C (while 0x10 not in flight) -> count=2; memory sees 0x10=C then 0x20=B.
- Fill DEPTH=4 entries with memory latency 8 cycles, then a fifth write -> c_ready held low until first mem_ready, asserted the cycle after the pop; no entry lost.
- Read miss 0x99 while DRAIN of 0x10 in flight -> mem_read for 0x99 issued only after 0x10's mem_ready. It precedes remaining drains; c_rdata = mem_rdata.
